// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline hazard/sequencing controller:
//   - register-file addressing widths
//   - FSM state encodings (PC_RUN, PC_FLUSH)
//   - width of the flush down-counter
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   localparam int unsigned REG_ADDR_SIZE = 5;
   localparam int unsigned NUM_REGS      = 1 << REG_ADDR_SIZE;

   // Flush length is at most 7 cycles, so the remaining-cycle count fits in 3 bits.
   localparam int unsigned FCNT_W        = 3;

   typedef enum logic [1:0] {
      PC_RUN   = 2'b00,
      PC_FLUSH = 2'b01
   } pc_state_e;

endpackage : pipeline_ctrl_pkg

// File: rtl/pipeline_ctrl_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// One pending bit per architectural register, marking destinations of
// instructions that have issued but not yet written back.
//   clk, reset            core clock, asynchronous active-high reset
//   set_en, set_addr      mark a register pending (issue of a writer)
//   clr_en, clr_addr      retire a pending register (writeback)
//   clr_all               drop every pending bit (exception)
//   rs1_addr/rs2_addr/rd_addr  combinational lookup addresses
//   rs1_pending/rs2_pending/rd_pending  lookup results from the registered state
//   pending_o             full scoreboard, for observation
// Bit 0 (x0) can never become pending.
// -----------------------------------------------------------------------------
module reg_scoreboard
   import pipeline_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     set_en,
   input  logic [REG_ADDR_SIZE-1:0] set_addr,
   input  logic                     clr_en,
   input  logic [REG_ADDR_SIZE-1:0] clr_addr,
   input  logic                     clr_all,
   input  logic [REG_ADDR_SIZE-1:0] rs1_addr,
   input  logic [REG_ADDR_SIZE-1:0] rs2_addr,
   input  logic [REG_ADDR_SIZE-1:0] rd_addr,
   output logic                     rs1_pending,
   output logic                     rs2_pending,
   output logic                     rd_pending,
   output logic [NUM_REGS-1:0]      pending_o
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Ordering below sets the precedence: a same-cycle set beats a clear of the
   // same bit, and clr_all beats both.
   always_comb begin
      // NOTE: assign every always_comb output first so no path leaves it unassigned (no latch).
      pending_d = pending_q;
      if (clr_en) pending_d[clr_addr] = 1'b0;
      if (set_en) pending_d[set_addr] = 1'b1;
      if (clr_all) pending_d = '0;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: this is a flop vector, not a RAM, so it takes the async reset like any control state.
      if (reset) pending_q <= '0;
      // NOTE: non-blocking assignment for all sequential state.
      else       pending_q <= pending_d;
   end

   assign rs1_pending = pending_q[rs1_addr];
   assign rs2_pending = pending_q[rs2_addr];
   assign rd_pending  = pending_q[rd_addr];
   assign pending_o   = pending_q;

endmodule : reg_scoreboard

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the five-stage in-order core.
//   clk, reset                    core clock, asynchronous active-high reset
//   dec_*                         instruction currently in decode
//   wb_valid/wb_rd_addr/wb_rd_wr  writeback retirement (clears scoreboard)
//   branch_taken                  redirect resolved in execute
//   exception_valid               exception taken at writeback
//   mem_busy                      data memory still busy in the memory stage
//   stall_*                       hold the stage's output registers
//   insert_nop_decode             decode emits a bubble
//   flush_*                       invalidate the stage's output
//   issue                         decode advances a real instruction
// All controls are combinational from state and inputs (zero latency).
// -----------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     dec_valid,
   input  logic [REG_ADDR_SIZE-1:0] dec_rs1_addr,
   input  logic [REG_ADDR_SIZE-1:0] dec_rs2_addr,
   input  logic                     dec_uses_rs1,
   input  logic                     dec_uses_rs2,
   input  logic [REG_ADDR_SIZE-1:0] dec_rd_addr,
   input  logic                     dec_rd_wr,
   input  logic                     wb_valid,
   input  logic [REG_ADDR_SIZE-1:0] wb_rd_addr,
   input  logic                     wb_rd_wr,
   input  logic                     branch_taken,
   input  logic                     exception_valid,
   input  logic                     mem_busy,
   output logic                     stall_fetch,
   output logic                     stall_decode,
   output logic                     stall_execute,
   output logic                     stall_mem,
   output logic                     insert_nop_decode,
   output logic                     flush_fetch,
   output logic                     flush_decode,
   output logic                     flush_execute,
   output logic                     flush_mem,
   output logic                     issue
);

   // The trigger cycle is the first flush cycle, so the counter covers the rest
   // minus the final FLUSH cycle that sees fcnt==0.
   localparam logic [FCNT_W-1:0] FCNT_LOAD =
      (FLUSH_CYCLES > 1) ? FCNT_W'(FLUSH_CYCLES - 2) : '0;

   pc_state_e           state_q;
   logic [FCNT_W-1:0]   fcnt_q;

   logic                rs1_pending;
   logic                rs2_pending;
   logic                rd_pending;
   logic                hazard;
   logic                trigger;
   logic                clr_all;
   logic [NUM_REGS-1:0] pending_unused;

   // WAW is treated as a hazard so a single pending bit per register suffices.
   assign hazard = dec_valid && ((dec_uses_rs1 && rs1_pending) ||
                                 (dec_uses_rs2 && rs2_pending) ||
                                 (dec_rd_wr    && rd_pending));

   assign issue  = dec_valid && !hazard && !mem_busy && !flush_decode;

   reg_scoreboard u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .set_en      (issue && dec_rd_wr && (dec_rd_addr != '0)),
      .set_addr    (dec_rd_addr),
      .clr_en      (wb_valid && wb_rd_wr),
      .clr_addr    (wb_rd_addr),
      .clr_all     (clr_all),
      .rs1_addr    (dec_rs1_addr),
      .rs2_addr    (dec_rs2_addr),
      .rd_addr     (dec_rd_addr),
      .rs1_pending (rs1_pending),
      .rs2_pending (rs2_pending),
      .rd_pending  (rd_pending),
      .pending_o   (pending_unused)
   );

   // Priority chain: exception > redirect (only when memory is idle, since a
   // frozen execute re-presents the branch) > memory freeze > flush drain > hazard.
   always_comb begin
      stall_fetch       = 1'b0;
      stall_decode      = 1'b0;
      stall_execute     = 1'b0;
      stall_mem         = 1'b0;
      insert_nop_decode = 1'b0;
      flush_fetch       = 1'b0;
      flush_decode      = 1'b0;
      flush_execute     = 1'b0;
      flush_mem         = 1'b0;
      trigger           = 1'b0;
      clr_all           = 1'b0;
      if (exception_valid) begin
         flush_fetch   = 1'b1;
         flush_decode  = 1'b1;
         flush_execute = 1'b1;
         flush_mem     = 1'b1;
         trigger       = 1'b1;
         clr_all       = 1'b1;
      end else if (branch_taken && !mem_busy) begin
         flush_fetch  = 1'b1;
         flush_decode = 1'b1;
         trigger      = 1'b1;
      end else if (mem_busy) begin
         stall_fetch   = 1'b1;
         stall_decode  = 1'b1;
         stall_execute = 1'b1;
         stall_mem     = 1'b1;
      end else if (state_q == PC_FLUSH) begin
         flush_fetch  = 1'b1;
         flush_decode = 1'b1;
      end else if (hazard) begin
         // Decode keeps its instruction because fetch stops feeding it.
         stall_fetch       = 1'b1;
         insert_nop_decode = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PC_RUN;
         fcnt_q  <= '0;
      end else if (trigger) begin
         if (FLUSH_CYCLES > 1) begin
            state_q <= PC_FLUSH;
            fcnt_q  <= FCNT_LOAD;
         end else begin
            state_q <= PC_RUN;
            fcnt_q  <= '0;
         end
      end else if (state_q == PC_FLUSH) begin
         if (fcnt_q == '0) state_q <= PC_RUN;
         else              fcnt_q  <= fcnt_q - 1'b1;
      end
   end

endmodule : pipeline_ctrl
